// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// State encoding, default widths and the ALU select codes used by requesters.
package alu_sched_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SEL_W = 4;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter.
// On contention the requester that did not win last time is granted.
module rr_arb2
  import alu_sched_pkg::*;
(
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  always_comb begin
    o_grant_idx = 1'b0;
    unique case (i_req_valid)
      2'b11:   o_grant_idx = ~i_last_grant;
      2'b10:   o_grant_idx = 1'b1;
      default: o_grant_idx = 1'b0;
    endcase
    o_grant = (|i_req_valid) ? idx_to_onehot(o_grant_idx) : 2'b00;
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Registered ALU operands, one execute cycle, then a held per-owner response.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [2*WIDTH-1:0]   i_req_a,
  input  logic [2*WIDTH-1:0]   i_req_b,
  input  logic [2*SEL_W-1:0]   i_req_sel,
  output logic [1:0]           o_rsp_valid,
  input  logic [1:0]           i_rsp_ready,
  output logic [WIDTH-1:0]     o_rsp_data,
  output logic                 o_rsp_carry,
  output logic [WIDTH-1:0]     o_alu_a,
  output logic [WIDTH-1:0]     o_alu_b,
  output logic [SEL_W-1:0]     o_alu_sel,
  input  logic [WIDTH-1:0]     i_alu_out,
  input  logic                 i_alu_carry,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_done_count
);

  state_e             r_state, w_state_d;
  logic               r_owner;
  logic               r_last_grant;
  logic [WIDTH-1:0]   r_alu_a, r_alu_b, r_rsp_data;
  logic [SEL_W-1:0]   r_alu_sel;
  logic               r_rsp_carry;
  logic [CNT_W-1:0]   r_done_count;

  logic [1:0]         w_grant;
  logic               w_grant_idx;
  logic               w_req_hs;
  logic               w_rsp_hs;

  rr_arb2 u_arb (
    .i_req_valid  (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  assign w_req_hs = (r_state == StIdle) && (|i_req_valid);
  assign w_rsp_hs = (r_state == StResp) && i_rsp_ready[r_owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (|i_req_valid) w_state_d = StExec;
      StExec:  w_state_d = StResp;
      StResp:  if (i_rsp_ready[r_owner]) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == StIdle) ? w_grant : 2'b00;
    o_rsp_valid = (r_state == StResp) ? idx_to_onehot(r_owner) : 2'b00;
    o_busy      = (r_state != StIdle);
  end

  // Operands hold their last value while idle so the ALU inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_req_hs) begin
      r_alu_a      <= w_grant_idx ? i_req_a[WIDTH +: WIDTH] : i_req_a[0 +: WIDTH];
      r_alu_b      <= w_grant_idx ? i_req_b[WIDTH +: WIDTH] : i_req_b[0 +: WIDTH];
      r_alu_sel    <= w_grant_idx ? i_req_sel[SEL_W +: SEL_W] : i_req_sel[0 +: SEL_W];
      r_owner      <= w_grant_idx;
      r_last_grant <= w_grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
    end else if (r_state == StExec) begin
      r_rsp_data  <= i_alu_out;
      r_rsp_carry <= i_alu_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_count <= '0;
    end else if (w_rsp_hs) begin
      r_done_count <= r_done_count + 1'b1;
    end
  end

  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_sel    = r_alu_sel;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_carry  = r_rsp_carry;
  assign o_done_count = r_done_count;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed, table-driven bench for alu_op_scheduler with a behavioural ALU.
// A second instance with a 4-bit counter shares the stimulus to reach wrap-around.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, rsp_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_sel;

  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_data, alu_a, alu_b;
  logic        rsp_carry, busy;
  logic [3:0]  alu_sel;
  logic [15:0] done_count;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [7:0]  s_rsp_data, s_alu_a, s_alu_b;
  logic        s_rsp_carry, s_busy;
  logic [3:0]  s_alu_sel;
  logic [3:0]  s_done;

  logic [7:0]  alu_out;
  logic        alu_carry;

  always #5 clk = ~clk;

  // Behavioural ALU: add/sub report carry/borrow in bit 8.
  always_comb begin
    alu_out   = alu_a;
    alu_carry = 1'b0;
    case (alu_sel)
      ALU_ADD: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      4'h2:    alu_out = alu_a & alu_b;
      4'h3:    alu_out = alu_a | alu_b;
      4'h4:    alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a;
    endcase
  end

  alu_op_scheduler #(.WIDTH(8), .SEL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_sel(req_sel),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_carry(rsp_carry),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
    .i_alu_out(alu_out), .i_alu_carry(alu_carry),
    .o_busy(busy), .o_done_count(done_count)
  );

  alu_op_scheduler #(.WIDTH(8), .SEL_W(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(s_req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_sel(req_sel),
    .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(s_rsp_data), .o_rsp_carry(s_rsp_carry),
    .o_alu_a(s_alu_a), .o_alu_b(s_alu_b), .o_alu_sel(s_alu_sel),
    .i_alu_out(alu_out), .i_alu_carry(alu_carry),
    .o_busy(s_busy), .o_done_count(s_done)
  );

  typedef struct {
    int         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] d;
    logic       c;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] exp_done = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive_req(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] sel);
    req_a[r*8 +: 8]   = a;
    req_b[r*8 +: 8]   = b;
    req_sel[r*4 +: 4] = sel;
  endtask

  task automatic run_op(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.r;
    @(negedge clk);
    drive_req(v.r, v.a, v.b, v.sel);
    req_valid = oh;
    #1;
    chk("req_ready", req_ready, oh);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_req_ready", req_ready, 0);
    chk("alu_a", alu_a, v.a);
    chk("alu_b", alu_b, v.b);
    chk("alu_sel", alu_sel, v.sel);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, v.d);
    chk("rsp_carry", rsp_carry, v.c);
    rsp_ready = oh;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    exp_done++;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_count", done_count, exp_done);
  endtask

  vec_t vecs[6];
  int   g, k;

  initial begin
    vecs[0] = '{r: 0, a: 8'h0A, b: 8'h02, sel: ALU_ADD, d: 8'h0C, c: 1'b0};
    vecs[1] = '{r: 0, a: 8'h05, b: 8'h07, sel: ALU_SUB, d: 8'hFE, c: 1'b1};
    vecs[2] = '{r: 1, a: 8'hF6, b: 8'h0A, sel: ALU_ADD, d: 8'h00, c: 1'b1};
    vecs[3] = '{r: 1, a: 8'h30, b: 8'h10, sel: ALU_SUB, d: 8'h20, c: 1'b0};
    vecs[4] = '{r: 0, a: 8'hFF, b: 8'h01, sel: ALU_ADD, d: 8'h00, c: 1'b1};
    vecs[5] = '{r: 1, a: 8'hF0, b: 8'h3C, sel: 4'h2,    d: 8'h30, c: 1'b0};

    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_sel = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_done", done_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Contention: last grant was requester 1, so 0 leads and they alternate.
    drive_req(0, 8'h01, 8'h01, ALU_ADD);
    drive_req(1, 8'h10, 8'h20, ALU_ADD);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    g = 0; k = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("cont_grant", req_ready, 2'b01 << (g % 2));
        g++;
      end
      if (rsp_valid != 2'b00) begin
        chk("cont_rsp_valid", rsp_valid, 2'b01 << (k % 2));
        chk("cont_rsp_data", rsp_data, (k % 2) ? 8'h30 : 8'h02);
        k++;
      end
      if (i == 11) req_valid = 2'b00;
      @(negedge clk);
    end
    rsp_ready = 2'b00;
    exp_done += 16'd4;
    #1;
    chk("cont_grants", g, 4);
    chk("cont_rsps", k, 4);
    chk("cont_done", done_count, exp_done);
    chk("cont_idle", busy, 0);

    // Backpressure on requester 0 while requester 1 waits and asserts rsp_ready.
    @(negedge clk);
    drive_req(0, 8'h11, 8'h22, ALU_ADD);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_rsp_data", rsp_data, 8'h33);
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    exp_done++;
    @(negedge clk);
    #1;
    chk("bp_release_busy", busy, 0);
    chk("bp_release_grant", req_ready, 2'b10);
    chk("bp_done", done_count, exp_done);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("drop_busy", busy, 0);
    chk("drop_done", done_count, exp_done);

    // Reset while a response is pending.
    @(negedge clk);
    drive_req(0, 8'h01, 8'h02, ALU_ADD);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_rsp_valid", rsp_valid, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_done", done_count, 0);
    exp_done = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_done", done_count, 0);
    end
    rsp_ready = 2'b00;

    // After reset requester 0 wins; then 16 back-to-back lone ops wrap the 4-bit counter.
    @(negedge clk);
    drive_req(0, 8'h03, 8'h04, ALU_ADD);
    drive_req(1, 8'h05, 8'h06, ALU_ADD);
    req_valid = 2'b11;
    #1;
    chk("post_rst_priority", req_ready, 2'b01);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (i == 45) chk("wrap_pre", s_done, 4'hF);
      if (i == 47) req_valid = 2'b00;
    end
    rsp_ready = 2'b00;
    #1;
    chk("wrap_small", s_done, 4'h0);
    chk("wrap_main", done_count, 16'd16);
    chk("wrap_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
